stop_watch_lap: RTL and testbench

Parametrised BCD stopwatch/timer for the board display path. Counts N_DIGITS decimal digits at a programmable tick rate, up or down, with a presettable start value, a lap (display-freeze) function and selectable wrap or saturate behaviour at the terminal count. It drives the seven-segment multiplexer directly and replaces the fixed four-digit up-only stopwatch.

---
 rtl/stop_watch_pkg.sv | 27 ++
 rtl/bcd_updown_digit.sv | 55 +++++
 rtl/stop_watch_lap.sv | 143 ++++++++++++++
 tb/tb_stop_watch_lap.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// ============================================================================
// Module   : stop_watch_pkg
// Brief    : Shared types and constants for the BCD stopwatch.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stop_watch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_updown_digit.sv
// ============================================================================
// Module   : bcd_updown_digit
// Brief    : One BCD digit with ripple carry/borrow, sync clear and preset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_updown_digit
    import stop_watch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic en_i,
    input  logic down_i,
    input  logic cin_i,
    output logic cout_o,
    output bcd_t digit_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (load_i) begin
            digit_d = bcd_clamp(load_val_i);
        end else if (en_i && cin_i) begin
            if (down_i) begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Carry/borrow propagates only while every lower digit is at its limit.
    assign cout_o  = cin_i && (down_i ? (digit_q == 4'd0) : (digit_q == BCD_MAX));
    assign digit_o = digit_q;

endmodule

`default_nettype wire

// File: rtl/stop_watch_lap.sv
// ============================================================================
// Module   : stop_watch_lap
// Brief    : Up/down BCD stopwatch with prescaler, lap hold, wrap/saturate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stop_watch_lap
    import stop_watch_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 10_000_000,
    parameter bit WRAP     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  go_i,
    input  logic                  down_i,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] load_val_i,
    input  logic                  lap_i,
    output logic [4*N_DIGITS-1:0] digits_o,
    output logic                  running_o,
    output logic                  lap_active_o,
    output logic                  tick_o,
    output logic                  expired_o,
    output logic                  ovf_o
);

    localparam int                   C_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(TICK_DIV - 1);
    localparam logic [4*N_DIGITS-1:0] C_ONE       = {{(4*N_DIGITS-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [C_PRESC_W-1:0]    presc_q, presc_d;
    logic [4*N_DIGITS-1:0]   snap_q, snap_d;
    logic                    lap_active_q, lap_active_d;
    logic                    ovf_q, ovf_d;

    logic [4*N_DIGITS-1:0]   count;
    logic [N_DIGITS:0]       carry;
    logic                    is_run, is_pause, load_ok, lap_ok;
    logic                    tick, at_limit, terminal, step, wrap_evt;

    assign is_run   = (state_q == RUN);
    assign is_pause = (state_q == PAUSED);
    assign load_ok  = load_i && !clr_i && (state_q == IDLE || is_pause);
    assign lap_ok   = lap_i && !clr_i && !load_ok && (is_run || is_pause);
    assign tick     = is_run && (presc_q == C_PRESC_LAST);

    // Final carry: all-9s when counting up, all-0s when counting down.
    assign carry[0] = 1'b1;
    assign at_limit = carry[N_DIGITS];
    assign wrap_evt = tick && !down_i && at_limit;
    assign step     = tick && !(at_limit && (down_i || !WRAP));
    assign terminal = tick && (down_i ? (count == C_ONE || at_limit) : (at_limit && !WRAP));

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        bcd_updown_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (clr_i),
            .load_i     (load_ok),
            .load_val_i (load_val_i[4*i +: 4]),
            .en_i       (step),
            .down_i     (down_i),
            .cin_i      (carry[i]),
            .cout_o     (carry[i+1]),
            .digit_o    (count[4*i +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_i) state_d = (down_i && count == '0) ? EXPIRED : RUN;
            RUN: begin
                if (terminal)   state_d = EXPIRED;
                else if (!go_i) state_d = PAUSED;
            end
            PAUSED:  if (go_i) state_d = RUN;
            EXPIRED: state_d = EXPIRED;
            default: state_d = IDLE;
        endcase
        if (clr_i) state_d = IDLE;
    end

    always_comb begin
        presc_d      = presc_q;
        snap_d       = snap_q;
        lap_active_d = lap_active_q;
        ovf_d        = ovf_q;
        if (clr_i) begin
            presc_d      = '0;
            snap_d       = '0;
            lap_active_d = 1'b0;
            ovf_d        = 1'b0;
        end else begin
            if (load_ok) begin
                presc_d = '0;
            end else if (is_run) begin
                presc_d = tick ? '0 : presc_q + C_PRESC_W'(1);
            end
            // A second lap while paused and frozen releases the hold.
            if (lap_ok) begin
                if (is_pause && lap_active_q) begin
                    lap_active_d = 1'b0;
                end else begin
                    snap_d       = count;
                    lap_active_d = 1'b1;
                end
            end
            if (wrap_evt) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            snap_q       <= '0;
            lap_active_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            snap_q       <= snap_d;
            lap_active_q <= lap_active_d;
            ovf_q        <= ovf_d;
        end
    end

    assign digits_o     = lap_active_q ? snap_q : count;
    assign running_o    = is_run;
    assign lap_active_o = lap_active_q;
    assign tick_o       = tick;
    assign expired_o    = (state_q == EXPIRED);
    assign ovf_o        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_stop_watch_lap.sv
// ============================================================================
// Module   : tb_stop_watch_lap
// Brief    : Self-checking bench for stop_watch_lap (WRAP=1 and WRAP=0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stop_watch_lap;

    localparam int N    = 3;
    localparam int TD   = 4;
    localparam int MAXV = 999;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic        clk, rst_n, clr, go, down, load, lap;
    logic [11:0] load_val;

    logic [11:0] dig0, dig1;
    logic        run0, run1, la0, la1, tk0, tk1, ex0, ex1, ov0, ov1;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    stop_watch_lap #(.N_DIGITS(N), .TICK_DIV(TD), .WRAP(1'b1)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .go_i(go), .down_i(down),
        .load_i(load), .load_val_i(load_val), .lap_i(lap),
        .digits_o(dig0), .running_o(run0), .lap_active_o(la0),
        .tick_o(tk0), .expired_o(ex0), .ovf_o(ov0)
    );

    stop_watch_lap #(.N_DIGITS(N), .TICK_DIV(TD), .WRAP(1'b0)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .go_i(go), .down_i(down),
        .load_i(load), .load_val_i(load_val), .lap_i(lap),
        .digits_o(dig1), .running_o(run1), .lap_active_o(la1),
        .tick_o(tk1), .expired_o(ex1), .ovf_o(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int count;
        int presc;
        int snap;
        bit lap_a;
        bit ovf;
    } m_t;

    m_t m [2];

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_dec(input logic [11:0] b);
        int v, w, d;
        v = 0;
        w = 1;
        for (int i = 0; i < N; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    // Next model state from the current one and the inputs sampled at this edge.
    function automatic m_t m_next(input m_t s, input bit wrap);
        m_t n;
        bit t;
        n = s;
        t = (s.mode == M_RUN) && (s.presc == TD - 1);
        if (clr) begin
            n = '{default: 0};
            return n;
        end
        if (load && (s.mode == M_IDLE || s.mode == M_PAUSED)) begin
            n.count = clamp_dec(load_val);
            n.presc = 0;
        end else if (lap && (s.mode == M_RUN || s.mode == M_PAUSED)) begin
            if (s.mode == M_PAUSED && s.lap_a) begin
                n.lap_a = 1'b0;
            end else begin
                n.snap  = s.count;
                n.lap_a = 1'b1;
            end
        end
        if (s.mode == M_RUN) n.presc = t ? 0 : s.presc + 1;
        case (s.mode)
            M_IDLE: if (go) n.mode = (down && s.count == 0) ? M_EXP : M_RUN;
            M_RUN: begin
                if (!go) n.mode = M_PAUSED;
                if (t) begin
                    if (!down) begin
                        if (s.count == MAXV) begin
                            n.ovf = 1'b1;
                            if (wrap) n.count = 0;
                            else      n.mode  = M_EXP;
                        end else begin
                            n.count = s.count + 1;
                        end
                    end else begin
                        if (s.count > 0) n.count = s.count - 1;
                        if (n.count == 0) n.mode = M_EXP;
                    end
                end
            end
            M_PAUSED: if (go) n.mode = M_RUN;
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] = '{default: 0};
            m[1] = '{default: 0};
        end else begin
            m[0] = m_next(m[0], 1'b1);
            m[1] = m_next(m[1], 1'b0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp_inst(input int k, input logic [11:0] d, input logic r,
                            input logic l, input logic t, input logic e, input logic o);
        m_t s;
        s = m[k];
        chk($sformatf("model_digits%0d", k), 32'(d), 32'(to_bcd(s.lap_a ? s.snap : s.count)));
        chk($sformatf("model_running%0d", k), 32'(r), 32'(s.mode == M_RUN));
        chk($sformatf("model_lap%0d", k), 32'(l), 32'(s.lap_a));
        chk($sformatf("model_tick%0d", k), 32'(t), 32'(s.mode == M_RUN && s.presc == TD - 1));
        chk($sformatf("model_expired%0d", k), 32'(e), 32'(s.mode == M_EXP));
        chk($sformatf("model_ovf%0d", k), 32'(o), 32'(s.ovf));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, dig0, run0, la0, tk0, ex0, ov0);
            cmp_inst(1, dig1, run1, la1, tk1, ex1, ov1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [11:0] v);
        load_val = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    task automatic do_clr();
        go  = 1'b0;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; go = 1'b0; down = 1'b0;
        load = 1'b0; lap = 1'b0; load_val = 12'h000;
        step(2);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        step(1);
        chk("reset_digits", 32'(dig0), 32'h000);
        chk("reset_running", 32'(run0), 32'd0);

        // Up count with wrap (instance 0) and saturation (instance 1)
        do_load(12'h998);
        chk("load_998", 32'(dig0), 32'h998);
        go = 1'b1;
        step(1);
        chk("run_entry", 32'(run0), 32'd1);
        step(4);
        chk("up_999_w", 32'(dig0), 32'h999);
        chk("up_999_s", 32'(dig1), 32'h999);
        step(3);
        chk("tick_pulse", 32'(tk0), 32'd1);
        step(1);
        chk("wrap_000", 32'(dig0), 32'h000);
        chk("wrap_ovf", 32'(ov0), 32'd1);
        chk("wrap_running", 32'(run0), 32'd1);
        chk("sat_999", 32'(dig1), 32'h999);
        chk("sat_expired", 32'(ex1), 32'd1);
        chk("sat_ovf", 32'(ov1), 32'd1);
        chk("sat_running", 32'(run1), 32'd0);
        step(5);
        chk("sat_hold", 32'(dig1), 32'h999);
        do_clr();
        chk("clr_ovf", 32'(ov0), 32'd0);

        // Down timer
        down = 1'b1;
        do_load(12'h003);
        go = 1'b1;
        step(1);
        step(4);
        chk("down_002", 32'(dig0), 32'h002);
        step(4);
        chk("down_001", 32'(dig0), 32'h001);
        chk("down_not_exp", 32'(ex0), 32'd0);
        step(4);
        chk("down_000", 32'(dig0), 32'h000);
        chk("down_expired", 32'(ex0), 32'd1);
        chk("down_ovf", 32'(ov0), 32'd0);
        step(2);
        chk("exp_hold", 32'(dig1), 32'h000);
        do_clr();
        down = 1'b0;

        // Pause with partial prescaler
        do_load(12'h005);
        go = 1'b1;
        step(2);
        go = 1'b0;
        step(1);
        chk("paused_running", 32'(run0), 32'd0);
        step(3);
        chk("paused_digits", 32'(dig0), 32'h005);
        chk("paused_tick", 32'(tk0), 32'd0);
        go = 1'b1;
        step(2);
        chk("resume_tick", 32'(tk0), 32'd1);
        step(1);
        chk("resume_006", 32'(dig0), 32'h006);

        // Lap freeze, split, release, clr-over-lap
        step(4);
        chk("pre_lap_007", 32'(dig0), 32'h007);
        lap = 1'b1; step(1); lap = 1'b0;
        step(3);
        chk("lap_freeze", 32'(dig0), 32'h007);
        chk("lap_active", 32'(la0), 32'd1);
        step(16);
        lap = 1'b1; step(1); lap = 1'b0;
        chk("lap_split", 32'(dig0), 32'h012);
        go = 1'b0;
        step(1);
        lap = 1'b1; step(1); lap = 1'b0;
        chk("lap_release", 32'(la0), 32'd0);
        chk("lap_live", 32'(dig0), 32'h012);
        lap = 1'b1; step(1); lap = 1'b0;
        chk("lap_again", 32'(la0), 32'd1);
        clr = 1'b1; lap = 1'b1; step(1); clr = 1'b0; lap = 1'b0;
        chk("clr_beats_lap", 32'(la0), 32'd0);
        chk("clr_digits", 32'(dig0), 32'h000);

        // Clamp of out-of-range preset digits
        do_load(12'hFA3);
        chk("load_clamp", 32'(dig0), 32'h993);
        do_clr();

        // Asynchronous reset mid-run
        do_load(12'h045);
        go = 1'b1;
        step(2);
        chk("run_045", 32'(dig0), 32'h045);
        rst_n = 1'b0;
        #1;
        chk("async_digits", 32'(dig0), 32'h000);
        chk("async_running", 32'(run0), 32'd0);
        chk("async_tick", 32'(tk0), 32'd0);
        go = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("post_reset_digits", 32'(dig0), 32'h000);
        chk("post_reset_expired", 32'(ex1), 32'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
